// File: rtl/aes_row_rotator.sv
// Byte-serial AES ShiftRows: rows ping-pong through an external 2x4-byte memory.
// Define AES_ROW_ROT_INV_EN to add the inv port and InvShiftRows support.
module aes_row_rotator (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       mem_wr_en,
    output logic [2:0] mem_wr_addr,
    output logic [7:0] mem_wr_data,
    output logic [2:0] mem_rd_addr,
    input  logic [7:0] mem_rd_data
`ifdef AES_ROW_ROT_INV_EN
    ,
    input  logic       inv
`endif
);

    logic       r_wr_bank;
    logic [1:0] r_wr_col;
    logic [1:0] r_wr_row;
    logic       r_rd_bank;
    logic [1:0] r_rd_col;
    logic [1:0] r_full;
    logic [1:0] r_row_tag [2];

    logic       w_accept;
    logic       w_drain;
    logic       w_wr_row_done;
    logic       w_rd_row_done;
    logic [1:0] w_rd_tag;
    logic [1:0] w_rd_col_rot;
    logic       w_rd_inv;

    // Column arithmetic is 2-bit so the carry falls off and the rotation wraps.
    function automatic logic [1:0] rot_col(input logic [1:0] col,
                                           input logic [1:0] tag,
                                           input logic       inv_mode);
        return inv_mode ? (col - tag) : (col + tag);
    endfunction

`ifdef AES_ROW_ROT_INV_EN
    logic [1:0] r_inv_tag;
    logic       r_inv_state;
    logic       w_inv_now;

    // The r0c0 byte's inv value must reach row 0's tag even when that row is written now.
    assign w_inv_now = (r_wr_row == 2'd0 && r_wr_col == 2'd0) ? inv : r_inv_state;
    assign w_rd_inv  = r_inv_tag[r_rd_bank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv_tag   <= 2'b00;
            r_inv_state <= 1'b0;
        end else begin
            if (w_accept && r_wr_row == 2'd0 && r_wr_col == 2'd0)
                r_inv_state <= inv;
            if (w_wr_row_done)
                r_inv_tag[r_wr_bank] <= w_inv_now;
        end
    end
`else
    assign w_rd_inv = 1'b0;
`endif

    assign in_ready      = ~r_full[r_wr_bank];
    assign w_accept      = in_valid & in_ready;
    assign w_wr_row_done = w_accept & (r_wr_col == 2'd3);

    assign mem_wr_en     = w_accept;
    assign mem_wr_addr   = {r_wr_bank, r_wr_col};
    assign mem_wr_data   = in_data;

    assign out_valid     = r_full[r_rd_bank];
    assign w_drain       = out_valid & out_ready;
    assign w_rd_row_done = w_drain & (r_rd_col == 2'd3);
    assign w_rd_tag      = r_row_tag[r_rd_bank];
    assign w_rd_col_rot  = rot_col(r_rd_col, w_rd_tag, w_rd_inv);

    assign mem_rd_addr   = {r_rd_bank, w_rd_col_rot};
    assign out_data      = mem_rd_data;
    assign out_last      = out_valid & (r_rd_col == 2'd3) & (w_rd_tag == 2'd3);

    // Write side: fill one bank, tag it with its row index, then swap banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank    <= 1'b0;
            r_wr_col     <= 2'd0;
            r_wr_row     <= 2'd0;
            r_row_tag[0] <= 2'd0;
            r_row_tag[1] <= 2'd0;
        end else if (w_accept) begin
            r_wr_col <= r_wr_col + 2'd1;
            if (w_wr_row_done) begin
                r_row_tag[r_wr_bank] <= r_wr_row;
                r_wr_bank            <= ~r_wr_bank;
                r_wr_row             <= r_wr_row + 2'd1;
            end
        end
    end

    // Read side: drain the other bank; fill and drain never target the same bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_bank <= 1'b0;
            r_rd_col  <= 2'd0;
            r_full    <= 2'b00;
        end else begin
            if (w_drain)
                r_rd_col <= r_rd_col + 2'd1;
            if (w_rd_row_done) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            if (w_wr_row_done)
                r_full[r_wr_bank] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_row_rotator.sv
// Directed bench for aes_row_rotator with a behavioural 8-byte ping-pong memory.
module tb_aes_row_rotator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       mem_wr_en;
    logic [2:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic [2:0] mem_rd_addr;
    logic [7:0] mem_rd_data;
`ifdef AES_ROW_ROT_INV_EN
    logic       inv;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mem [8];
    logic [7:0] out_q [$];
    logic       last_q [$];
    int         cyc_q [$];

    // Hand-derived output orders (index into the 16-byte input state).
    int fwd_idx [16] = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};
    int inv_idx [16] = '{0, 1, 2, 3, 7, 4, 5, 6, 10, 11, 8, 9, 13, 14, 15, 12};

    always #5 clk = ~clk;

    aes_row_rotator dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data)
`ifdef AES_ROW_ROT_INV_EN
        ,
        .inv         (inv)
`endif
    );

    always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    assign mem_rd_data = mem[mem_rd_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: a byte is taken at the next rising edge when valid and ready.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            out_q.push_back(out_data);
            last_q.push_back(out_last);
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int start, input int n);
        for (int i = 0; i < n; i++) send(8'(start + i));
    endtask

    task automatic drain(input int n);
        int w;
        w = 0;
        while (out_q.size() < n && w < 500) begin
            tick();
            w++;
        end
        check("drain_count", 32'(out_q.size()), 32'(n));
    endtask

    task automatic check_tab(input string tag, input int base, input int off, input bit inverse);
        for (int i = 0; i < 16; i++) begin
            if (off + i < out_q.size()) begin
                check({tag, "_data"}, 32'(out_q[off + i]),
                      32'(8'(base + (inverse ? inv_idx[i] : fwd_idx[i]))));
                check({tag, "_last"}, 32'(last_q[off + i]), 32'(i == 15));
            end
        end
    endtask

    task automatic clear_q();
        out_q.delete();
        last_q.delete();
        cyc_q.delete();
    endtask

    initial begin
        logic [7:0] rin [$];
        int idx;
        int guard;
        int t0;
        int nlast;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef AES_ROW_ROT_INV_EN
        inv       = 1'b0;
`endif
        tick();
        tick();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_wr_en_lo", 32'(mem_wr_en), 32'd0);
        check("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
        check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        in_valid = 1'b1;
        #1;
        check("rst_wr_en_hi", 32'(mem_wr_en), 32'd1);
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();

        // Forward shift with first-byte latency
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            check("lat_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h00);
        send_range(4, 12);
        drain(16);
        check_tab("fwd", 0, 0, 1'b0);
        clear_q();

        // Back-to-back states, no idle cycles
        t0 = cyc;
        send_range(0, 32);
        check("b2b_in_cycles", 32'(cyc - t0), 32'd32);
        drain(32);
        check_tab("b2b0", 8'h00, 0, 1'b0);
        check_tab("b2b1", 8'h10, 16, 1'b0);
        if (cyc_q.size() == 32) check("b2b_out_span", 32'(cyc_q[31] - cyc_q[0]), 32'd31);
        clear_q();

        // Backpressure: both banks fill, then release
        out_ready = 1'b0;
        send_range(0, 7);
        check("bp_ready_b7", 32'(in_ready), 32'd1);
        send(8'h07);
        in_valid = 1'b1;
        in_data  = 8'h08;
        check("bp_ready_drop", 32'(in_ready), 32'd0);
        tick();
        tick();
        tick();
        check("bp_ready_held", 32'(in_ready), 32'd0);
        check("bp_valid_held", 32'(out_valid), 32'd1);
        check("bp_data_held", 32'(out_data), 32'h00);
        check("bp_last_lo", 32'(out_last), 32'd0);
        check("bp_no_output", 32'(out_q.size()), 32'd0);
        out_ready = 1'b1;
        send_range(8, 8);
        drain(16);
        check_tab("bp", 0, 0, 1'b0);
        clear_q();

        // Reset mid-row discards buffered bytes
        send_range(0, 6);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_wr_addr", 32'(mem_wr_addr), 32'd0);
        check("mid_rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        rst = 1'b0;
        tick();
        clear_q();
        out_ready = 1'b1;
        send_range(8'h20, 16);
        drain(16);
        check_tab("mid_rst", 8'h20, 0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("mid_rst_no_stale", 32'(out_q.size()), 32'd16);
        check("mid_rst_idle", 32'(out_valid), 32'd0);
        clear_q();

        // Random stalls over 50 states
        for (int i = 0; i < 800; i++) rin.push_back(8'($urandom_range(0, 255)));
        idx   = 0;
        guard = 0;
        while ((idx < 800 || out_q.size() < 800) && guard < 20000) begin
            in_valid  = (idx < 800) && ($urandom_range(0, 3) != 0);
            in_data   = (idx < 800) ? rin[idx] : 8'h00;
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rnd_in_count", 32'(idx), 32'd800);
        check("rnd_out_count", 32'(out_q.size()), 32'd800);
        nlast = 0;
        for (int s = 0; s < 50; s++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (s * 16 + r * 4 + c < out_q.size())
                        check("rnd_data", 32'(out_q[s * 16 + r * 4 + c]),
                              32'(rin[s * 16 + r * 4 + ((c + r) % 4)]));
                end
            end
        end
        foreach (last_q[i]) if (last_q[i]) nlast++;
        check("rnd_last_count", 32'(nlast), 32'd50);
        clear_q();

`ifdef AES_ROW_ROT_INV_EN
        // Inverse shift: inv only matters on the r0c0 byte
        inv = 1'b1;
        send(8'h00);
        inv = 1'b0;
        send_range(1, 15);
        drain(16);
        check_tab("inv", 0, 0, 1'b1);
        clear_q();
        send_range(0, 16);
        drain(16);
        check_tab("inv_off", 0, 0, 1'b0);
        clear_q();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
